// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Holds the forward-select encoding and the architectural PC register index.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    localparam int PC_REG = 15;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-register fields consumed by the hazard controller and the control it returns.
// The slave side is the controller; the master side is the pipeline datapath.
interface hazard_ctrl_if #(
    parameter int REGW = 4,
    parameter int CNTW = 32
);
    logic [REGW-1:0] RA1D;
    logic [REGW-1:0] RA2D;
    logic [REGW-1:0] RA1E;
    logic [REGW-1:0] RA2E;
    logic [REGW-1:0] WA3E;
    logic [REGW-1:0] WA3M;
    logic [REGW-1:0] WA3W;
    logic            RegWriteE;
    logic            RegWriteM;
    logic            RegWriteW;
    logic            MemtoRegE;
    logic            PCSrcD;
    logic            CondExE;
    logic            BranchTakenE;
    logic            PCSrcW;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;
    logic            PCWrPendingF;
    logic [CNTW-1:0] perf_stall_cnt;
    logic [CNTW-1:0] perf_flush_cnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        output PCSrcD, CondExE, BranchTakenE, PCSrcW,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  PCWrPendingF, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        input  PCSrcD, CondExE, BranchTakenE, PCSrcW,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output PCWrPendingF, perf_stall_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-select for one execute-stage operand: the newer M result beats W,
// and the PC register is never forwarded because it is read from its own path.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REGW = 4
) (
    input  logic [REGW-1:0] srcAddr_i,
    input  logic [REGW-1:0] wa3M_i,
    input  logic [REGW-1:0] wa3W_i,
    input  logic            regWriteM_i,
    input  logic            regWriteW_i,
    output fwd_e            fwdSel_o
);

    localparam logic [REGW-1:0] PC_ADDR = REGW'(PC_REG);

    always_comb begin
        fwdSel_o = FWD_RF;
        if (regWriteM_i && (srcAddr_i == wa3M_i) && (wa3M_i != PC_ADDR)) begin
            fwdSel_o = FWD_M;
        end else if (regWriteW_i && (srcAddr_i == wa3W_i) && (wa3W_i != PC_ADDR)) begin
            fwdSel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline, with a shadow tracker of PC writes in E/M.
// Optional saturating stall/flush performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REGW = 4,
    parameter int CNTW = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    fwd_e fwdA;
    fwd_e fwdB;
    logic ldrStall;
    logic pcWrPending;
    logic flushERaw;
    logic stallDRaw;
    logic pendE_q, pendE_d;
    logic pendM_q, pendM_d;

    hazard_ctrl_fwd_sel #(.REGW(REGW)) u_fwdA (
        .srcAddr_i   (hz.RA1E),
        .wa3M_i      (hz.WA3M),
        .wa3W_i      (hz.WA3W),
        .regWriteM_i (hz.RegWriteM),
        .regWriteW_i (hz.RegWriteW),
        .fwdSel_o    (fwdA)
    );

    hazard_ctrl_fwd_sel #(.REGW(REGW)) u_fwdB (
        .srcAddr_i   (hz.RA2E),
        .wa3M_i      (hz.WA3M),
        .wa3W_i      (hz.WA3W),
        .regWriteM_i (hz.RegWriteM),
        .regWriteW_i (hz.RegWriteW),
        .fwdSel_o    (fwdB)
    );

    // A load in E whose result decode needs: hold F/D one cycle and push a bubble into E.
    assign ldrStall    = hz.MemtoRegE & hz.RegWriteE &
                         ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));
    assign pcWrPending = hz.PCSrcD | pendE_q | pendM_q;
    assign flushERaw   = ldrStall | hz.BranchTakenE;
    assign stallDRaw   = ldrStall;

    // A flushed E slot never carries a PC write; a failed condition kills it before M.
    assign pendE_d = flushERaw ? 1'b0 : hz.PCSrcD;
    assign pendM_d = pendE_q & hz.CondExE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendE_q <= 1'b0;
            pendM_q <= 1'b0;
        end else begin
            pendE_q <= pendE_d;
            pendM_q <= pendM_d;
        end
    end

    assign hz.ForwardAE    = reset ? FWD_RF : fwdA;
    assign hz.ForwardBE    = reset ? FWD_RF : fwdB;
    assign hz.StallF       = ~reset & (ldrStall | pcWrPending);
    assign hz.StallD       = ~reset & stallDRaw;
    assign hz.FlushD       = ~reset & (pcWrPending | hz.PCSrcW | hz.BranchTakenE);
    assign hz.FlushE       = ~reset & flushERaw;
    assign hz.PCWrPendingF = ~reset & pcWrPending;

`ifdef HAZARD_PERF_EN
    logic [CNTW-1:0] stallCnt_q, stallCnt_d;
    logic [CNTW-1:0] flushCnt_q, flushCnt_d;

    assign stallCnt_d = (stallDRaw && (stallCnt_q != {CNTW{1'b1}})) ? stallCnt_q + 1'b1 : stallCnt_q;
    assign flushCnt_d = (flushERaw && (flushCnt_q != {CNTW{1'b1}})) ? flushCnt_q + 1'b1 : flushCnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign hz.perf_stall_cnt = stallCnt_q;
    assign hz.perf_flush_cnt = flushCnt_q;
`else
    assign hz.perf_stall_cnt = {CNTW{1'b0}};
    assign hz.perf_flush_cnt = {CNTW{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined processor.
- Consumes the destination-register, write-enable and PC-write flags carried by the execute, memory and writeback pipeline registers.
- Drives forwarding muxes, fetch/decode stalls and decode/execute flushes.
- Keeps its own shadow tracker of in-flight PC writes through E and M, so the pipeline registers need not carry PCSrc into the hazard logic for those stages.

Parameters:
- REGW, 4, register address width; register 15 is the PC.
- CNTW, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- RA1D  in  REGW  source reg 1, decode
- RA2D  in  REGW  source reg 2, decode
- RA1E  in  REGW  source reg 1, execute
- RA2E  in  REGW  source reg 2, execute
- WA3E  in  REGW  dest reg, execute
- WA3M  in  REGW  dest reg, memory
- WA3W  in  REGW  dest reg, writeback
- RegWriteE  in  1  execute writes regfile
- RegWriteM  in  1  memory-stage writes regfile
- RegWriteW  in  1  writeback writes regfile
- MemtoRegE  in  1  execute instr is a load
- PCSrcD  in  1  decoded instr writes PC
- CondExE  in  1  execute condition passed
- BranchTakenE  in  1  branch resolved taken in E
- PCSrcW  in  1  PC write in writeback
- ForwardAE  out  2  00 regfile, 01 from W, 10 from M
- ForwardBE  out  2  same encoding, operand B
- StallF  out  1  hold PC
- StallD  out  1  hold decode register
- FlushD  out  1  clear decode register
- FlushE  out  1  clear execute register
- PCWrPendingF  out  1  PC write in flight
- perf_stall_cnt  out  CNTW  StallD cycle count
- perf_flush_cnt  out  CNTW  FlushE cycle count

Behaviour:
- Always-on clock clk; reset is asynchronous, active-high.
- State: pend_e, pend_m (shadow PCSrc for E and M); optional counters.
- Reset: pend_e = 0, pend_m = 0, counters = 0.
- While reset is high, outputs are forced: Forward* = 00, Stall* = 0, Flush* = 0, PCWrPendingF = 0.
- Shadow update each posedge:
  - pend_e <= FlushE ? 0 : PCSrcD
  - pend_m <= pend_e & CondExE
- Forwarding (combinational, zero latency):
  - ForwardAE = 10 if RegWriteM & RA1E==WA3M & WA3M!=15.
  - Else ForwardAE = 01 if RegWriteW & RA1E==WA3W & WA3W!=15.
  - Else ForwardAE = 00.
  - ForwardBE uses RA2E with the same rules.
  - When M and W both match, M wins because it is newer.
- LDRstall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
  - The stall lasts exactly one cycle: the bubble inserted into E clears the match.
- PCWrPendingF = PCSrcD | pend_e | pend_m.
- StallF = LDRstall | PCWrPendingF.
- StallD = LDRstall.
- FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
- FlushE = LDRstall | BranchTakenE.
- Simultaneous events:
  - LDRstall with BranchTakenE: FlushE = 1, StallD = 1, FlushD = 1. The flush overrides the stall at the decode register; the branch wins.
  - PC-write instr with CondExE = 0: pend_m stays 0, so the pending window ends one cycle early.
- Reset mid-operation clears the shadow immediately; there is no stale pending PC write after release.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle StallD = 1.
  - perf_flush_cnt increments each cycle FlushE = 1.
  - Both are saturating at all-ones and cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package holds:
  - the forward-select enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - constant PC_REG = 15.
- One natural sub-module: fwd_sel.
  - Takes a source address plus M/W dest and write-enable.
  - Returns a forward select.
  - Instantiated twice, for operands A and B.

Test Plan:
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01.
- RA2E=15, WA3M=15, RegWriteM=1 -> ForwardBE=00.
- Load to r5 in E (MemtoRegE=1, RegWriteE=1, WA3E=5) with RA1D=5 -> StallF=StallD=FlushE=1 for one cycle. Next cycle with bubble in E (RegWriteE=0) -> all 0.
- PCSrcD=1 one cycle, CondExE=1 -> PCWrPendingF high 3 cycles. With CondExE=0 -> high 2 cycles. FlushD high through the PCSrcW cycle.
- LDRstall and BranchTakenE same cycle -> FlushE=1, FlushD=1, StallD=1. Then reset asserted mid-pending -> PCWrPendingF=0 asynchronously.
- HAZARD_PERF_EN defined: 4 load-use stalls -> perf_stall_cnt=4. Counter preloaded near all-ones -> saturates.
